mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage load/store unit. Turns a latched load/store into a
//                word-aligned data-memory request with byte enables, waits
//                for dmem_ready (bounded by TIMEOUT), aligns and extends load
//                data, and flags misaligned, illegal and timed-out accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [31:0] c_TIMEOUT   = 32'(TIMEOUT);
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    localparam logic [1:0]  c_ERR_NONE  = 2'b00;
    localparam logic [1:0]  c_ERR_ALIGN = 2'b01;
    localparam logic [1:0]  c_ERR_ILLEG = 2'b10;
    localparam logic [1:0]  c_ERR_TOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    // Latched access, held stable for the whole request phase
    logic [31:0]  r_addr;
    logic [2:0]   r_funct3;
    logic         r_we;
    logic [31:0]  r_wdata;
    logic [31:0]  r_cnt;
    logic         r_timeout;
    logic [31:0]  r_load_data;

    logic         w_access;
    logic         w_illegal;
    logic         w_misaligned;
    logic         w_accept;
    logic         w_in_req;
    logic [31:0]  w_cnt_inc;
    logic         w_timeout_hit;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_load_ext;

    // ------------------------------------------------------------------
    // Decode of the incoming access. funct3[1:0] is the size (byte, half,
    // word, reserved); funct3[2] selects zero-extension and only exists
    // for byte/half loads.
    // ------------------------------------------------------------------
    assign w_access     = mem_read | mem_write;
    assign w_illegal    = (mem_read & mem_write)
                        | (mem_funct3[1:0] == 2'b11)
                        | (mem_write & mem_funct3[2])
                        | (mem_read & mem_funct3[2] & (mem_funct3[1:0] == 2'b10));
    assign w_misaligned = ((mem_funct3[1:0] == 2'b01) & mem_addr[0])
                        | ((mem_funct3[1:0] == 2'b10) & (mem_addr[1:0] != 2'b00));
    assign w_accept     = w_access & ~w_illegal & ~w_misaligned;

    assign w_in_req      = (r_state == ST_REQ);
    assign w_cnt_inc     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 32'd1;
    // Ready always wins over the timeout in the same cycle
    assign w_timeout_hit = ~dmem_ready & (w_cnt_inc >= c_TIMEOUT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; all forced low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        mem_stall   = 1'b0;
        dmem_req    = 1'b0;
        load_valid  = 1'b0;
        err         = 1'b0;
        err_code    = c_ERR_NONE;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        mem_stall   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else if (w_access) begin
                        err      = 1'b1;
                        err_code = w_illegal ? c_ERR_ILLEG : c_ERR_ALIGN;
                    end
                end
                ST_REQ: begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_ready || w_timeout_hit) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    if (r_timeout) begin
                        err      = 1'b1;
                        err_code = c_ERR_TOUT;
                    end else begin
                        load_valid = ~r_we;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Store lane encoding: byte enables shifted by the low address bits,
    // data replicated so every enabled lane carries the right bytes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'd0;
        if (r_we) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << r_addr[1:0];
                    w_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r_wdata;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension of the returned word
    always_comb begin
        w_byte     = 8'd0;
        w_half     = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_ext = dmem_rdata;
        case (r_addr[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // Access latch, wait counter and load result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= 32'd0;
            r_funct3    <= 3'd0;
            r_we        <= 1'b0;
            r_wdata     <= 32'd0;
            r_cnt       <= 32'd0;
            r_timeout   <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= mem_addr;
                        r_funct3  <= mem_funct3;
                        r_we      <= mem_write;
                        r_wdata   <= mem_wdata;
                        r_cnt     <= 32'd0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dmem_ready) begin
                        if (!r_we) begin
                            r_load_data <= w_load_ext;
                        end
                    end else if (w_timeout_hit) begin
                        r_timeout   <= 1'b1;
                        r_load_data <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_timeout <= 1'b0;
                end
                default: begin
                    r_timeout <= 1'b0;
                end
            endcase
        end
    end

    // Bus fields are only driven while a request is outstanding
    assign dmem_we    = w_in_req & r_we;
    assign dmem_be    = w_in_req ? w_be : 4'd0;
    assign dmem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = w_in_req ? w_wdata : 32'd0;
    assign load_data  = r_load_data;

endmodule
`default_nettype wire
